reg_bank_fwd: RTL and testbench
===============================

Name: reg_bank_fwd

Overview:
Parametrised successor to the register bank block. It is a multi-register file with one write-back port and two read ports. Forwarding and immediate selection are built in: operand-source selection is computed internally from the in-flight destination tags, replacing the externally driven mux selects. It sits between decode and execute and registers A/B into the ID/EX boundary, with stall, flush and load-use bubble insertion.

Parameters:
DW, 8, data/operand width in bits
NREG, 32, number of architectural registers (power of 2, >=2)
AW, $clog2(NREG), register address width (derived localparam, not overridable)
INS_W, 24, instruction width
RSA_LSB, 10, LSB of source-A field in ins
RSB_LSB, 5, LSB of source-B field in ins
R0_ZERO, 1, 1 = register 0 reads as zero, ignores writes and is never forwarded

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
ins  in  INS_W  decode-stage instruction; rs_a = ins[RSA_LSB+:AW], rs_b = ins[RSB_LSB+:AW]
imm  in  DW  decoded immediate
imm_sel  in  1  1 = B operand takes imm
rd_ex, rd_dm, rd_wb  in  AW each  destination tags of EX/DM/WB stages
we_ex, we_dm, we_wb  in  1 each  stage will write its destination
ld_ex  in  1  EX-stage instruction is a load (result not yet available)
ans_ex, ans_dm, ans_wb  in  DW each  stage results
stall  in  1  hold outputs
flush  in  1  squash current decode instruction
A, B  out  DW each  registered operands
valid  out  1  A/B hold a real instruction
hazard  out  1  combinational load-use hazard; upstream must stall on it

Behaviour:
- Reset: all registers = 0; A = 0, B = 0, valid = 0. Reset overrides stall and flush.
- Write: at posedge, if we_wb and not (R0_ZERO and rd_wb == 0), write ans_wb to rd_wb.
- Operand resolution (combinational, per source s):
  - Priority: EX (we_ex, rd_ex == s) > DM > WB > register file.
  - With R0_ZERO, s == 0 always yields 0.
  - The WB match covers same-cycle write/read (write-through).
- B uses imm when imm_sel = 1; rs_b forwarding is then ignored and cannot raise hazard.
- hazard = ld_ex & we_ex & (rd_ex == rs_a or (!imm_sel and rd_ex == rs_b)), excluding rd_ex == 0 when R0_ZERO.
- Output register update, at posedge, in priority order:
  - rst: as reset.
  - stall: A, B, valid hold (the register file still accepts writes).
  - flush or hazard: A = 0, B = 0, valid = 0 (bubble).
  - otherwise: A, B = resolved operands; valid = 1.
- Latency: operands appear on A/B one cycle after ins is presented.
- Writes only ever arrive on the WB port; the EX and DM results are forward-only.
- Duplicate tags across stages resolve by priority with no error.
- When rs_a == rs_b, both operands take the same forwarded value.
- Reset asserted mid-stall clears the outputs immediately on that edge.

Decomposition:
- Shared package reg_bank_pkg:
  - FWD_RF/FWD_WB/FWD_DM/FWD_EX 2-bit select encodings (00/01/10/11, matching the legacy mux_sel convention)
  - DW/NREG defaults
- Sub-module reg_file:
  - NREG x DW storage
  - two asynchronous read ports, one synchronous write port
  - synchronous reset to zero
  - R0_ZERO handling
- Forward-select logic and output pipeline register stay in the top module.

Test Plan:
1. rst high 1 cycle, then ins selecting rs_a=3, rs_b=4, no stage writes, imm_sel=0 -> next cycle A=0x00, B=0x00, valid=1.
2. we_wb=1, rd_wb=3, ans_wb=0xE0 for one cycle; following cycle read rs_a=3 with no writes active -> A=0xE0. Also check same cycle with rs_a=3 -> A=0xE0 via write-through.
3. rs_a=7 with we_ex, we_dm and we_wb all set, rd_ex=rd_dm=rd_wb=7, ans_ex=0xC0, ans_dm=0xD0, ans_wb=0xE0 -> A=0xC0. Drop we_ex -> A=0xD0. Drop we_dm -> A=0xE0.
4. imm_sel=1, imm=0xFF, rs_b=7 matching rd_ex with ld_ex=1 -> B=0xFF, hazard=0. Then imm_sel=0 -> hazard=1 and next cycle valid=0, A=B=0.
5. Load A=0x12, B=0x34, assert stall 3 cycles while changing ins and answers -> A/B/valid unchanged. Then flush=1 -> A=B=0, valid=0.
6. R0_ZERO=1: we_wb=1, rd_wb=0, ans_wb=0xAA, and rd_ex=0 with ans_ex=0x55 -> reading rs_a=0 gives A=0x00 and hazard=0. Re-run with NREG=16, DW=16 -> 16-bit values forward correctly.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the forwarding register bank: operand-source select
// encodings, default sizes and the source-priority helper.
package reg_bank_pkg;

    localparam int DW_DEF   = 8;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_WB = 2'b01,
        FWD_DM = 2'b10,
        FWD_EX = 2'b11
    } fwd_sel_e;

    // Youngest in-flight producer wins: EX beats DM beats WB beats the file.
    function automatic fwd_sel_e pick_src(input logic hit_ex,
                                          input logic hit_dm,
                                          input logic hit_wb);
        if (hit_ex)      return FWD_EX;
        else if (hit_dm) return FWD_DM;
        else if (hit_wb) return FWD_WB;
        else             return FWD_RF;
    endfunction

endpackage

// File: rtl/reg_file.sv
// NREG x DW register file: one synchronous write port, two asynchronous read
// ports, synchronous reset to zero, optional hard-wired zero register.
module reg_file
    import reg_bank_pkg::*;
#(
    parameter  int DW      = DW_DEF,
    parameter  int NREG    = NREG_DEF,
    parameter  int R0_ZERO = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREG];
    logic          wr_en;

    assign wr_en = we_i && !((R0_ZERO != 0) && (waddr_i == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = ((R0_ZERO != 0) && (raddr_a_i == '0)) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = ((R0_ZERO != 0) && (raddr_b_i == '0)) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/reg_bank_fwd.sv
// Register bank with built-in operand forwarding, immediate select and the
// ID/EX operand register with stall, flush and load-use bubble insertion.
module reg_bank_fwd
    import reg_bank_pkg::*;
#(
    parameter  int DW      = DW_DEF,
    parameter  int NREG    = NREG_DEF,
    parameter  int INS_W   = 24,
    parameter  int RSA_LSB = 10,
    parameter  int RSB_LSB = 5,
    parameter  int R0_ZERO = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INS_W-1:0] ins,
    input  logic [DW-1:0]    imm,
    input  logic             imm_sel,
    input  logic [AW-1:0]    rd_ex,
    input  logic [AW-1:0]    rd_dm,
    input  logic [AW-1:0]    rd_wb,
    input  logic             we_ex,
    input  logic             we_dm,
    input  logic             we_wb,
    input  logic             ld_ex,
    input  logic [DW-1:0]    ans_ex,
    input  logic [DW-1:0]    ans_dm,
    input  logic [DW-1:0]    ans_wb,
    input  logic             stall,
    input  logic             flush,
    output logic [DW-1:0]    A,
    output logic [DW-1:0]    B,
    output logic             valid,
    output logic             hazard
);

    logic [AW-1:0] rs_a, rs_b;
    logic [DW-1:0] rf_a, rf_b;
    logic          zero_a, zero_b, zero_ex;
    fwd_sel_e      sel_a, sel_b;
    logic [DW-1:0] op_a, op_b_fwd, op_b;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic          valid_q, valid_d;
    logic          unused_ins;

    assign rs_a       = ins[RSA_LSB +: AW];
    assign rs_b       = ins[RSB_LSB +: AW];
    assign unused_ins = ^ins;

    reg_file #(
        .DW      (DW),
        .NREG    (NREG),
        .R0_ZERO (R0_ZERO)
    ) u_rf (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (we_wb),
        .waddr_i   (rd_wb),
        .wdata_i   (ans_wb),
        .raddr_a_i (rs_a),
        .raddr_b_i (rs_b),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    // Register 0 never matches a stage, so it falls through to the file's zero.
    assign zero_a  = (R0_ZERO != 0) && (rs_a == '0);
    assign zero_b  = (R0_ZERO != 0) && (rs_b == '0);
    assign zero_ex = (R0_ZERO != 0) && (rd_ex == '0);

    always_comb begin
        sel_a = pick_src(we_ex && (rd_ex == rs_a) && !zero_a,
                         we_dm && (rd_dm == rs_a) && !zero_a,
                         we_wb && (rd_wb == rs_a) && !zero_a);
        sel_b = pick_src(we_ex && (rd_ex == rs_b) && !zero_b,
                         we_dm && (rd_dm == rs_b) && !zero_b,
                         we_wb && (rd_wb == rs_b) && !zero_b);
    end

    always_comb begin
        op_a = rf_a;
        unique case (sel_a)
            FWD_EX:  op_a = ans_ex;
            FWD_DM:  op_a = ans_dm;
            FWD_WB:  op_a = ans_wb;
            default: op_a = rf_a;
        endcase
        op_b_fwd = rf_b;
        unique case (sel_b)
            FWD_EX:  op_b_fwd = ans_ex;
            FWD_DM:  op_b_fwd = ans_dm;
            FWD_WB:  op_b_fwd = ans_wb;
            default: op_b_fwd = rf_b;
        endcase
        op_b = imm_sel ? imm : op_b_fwd;
    end

    assign hazard = ld_ex && we_ex && !zero_ex &&
                    ((rd_ex == rs_a) || (!imm_sel && (rd_ex == rs_b)));

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        if (stall) begin
            a_d     = a_q;
            b_d     = b_q;
            valid_d = valid_q;
        end else if (flush || hazard) begin
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else begin
            a_d     = op_a;
            b_d     = op_b;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_reg_bank_fwd.sv
// Self-checking bench for reg_bank_fwd: an 8-bit/32-register and a
// 16-bit/16-register instance share stimulus and are checked against a model.
module tb_reg_bank_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] ins;
    logic [15:0] imm, ans_ex, ans_dm, ans_wb;
    logic        imm_sel, we_ex, we_dm, we_wb, ld_ex, stall, flush;
    logic [4:0]  rd_ex, rd_dm, rd_wb;

    logic [7:0]  a8, b8;
    logic        v8, h8;
    logic [15:0] a16, b16;
    logic        v16, h16;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_bank_fwd dut8 (
        .clk(clk), .rst(rst), .ins(ins), .imm(imm[7:0]), .imm_sel(imm_sel),
        .rd_ex(rd_ex), .rd_dm(rd_dm), .rd_wb(rd_wb),
        .we_ex(we_ex), .we_dm(we_dm), .we_wb(we_wb), .ld_ex(ld_ex),
        .ans_ex(ans_ex[7:0]), .ans_dm(ans_dm[7:0]), .ans_wb(ans_wb[7:0]),
        .stall(stall), .flush(flush),
        .A(a8), .B(b8), .valid(v8), .hazard(h8)
    );

    reg_bank_fwd #(.DW(16), .NREG(16)) dut16 (
        .clk(clk), .rst(rst), .ins(ins), .imm(imm), .imm_sel(imm_sel),
        .rd_ex(rd_ex[3:0]), .rd_dm(rd_dm[3:0]), .rd_wb(rd_wb[3:0]),
        .we_ex(we_ex), .we_dm(we_dm), .we_wb(we_wb), .ld_ex(ld_ex),
        .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
        .stall(stall), .flush(flush),
        .A(a16), .B(b16), .valid(v16), .hazard(h16)
    );

    // ---------------- behavioural model (cfg 0 = 8/32, cfg 1 = 16/16) -------
    logic [15:0] m_rf [2][32];
    logic [15:0] m_a [2];
    logic [15:0] m_b [2];
    logic        m_v [2];

    function automatic int amask(input int c);
        return (c == 0) ? 31 : 15;
    endfunction

    function automatic logic [15:0] dmask(input int c);
        return (c == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    function automatic int src_a(input int c);
        return int'(ins >> 10) & amask(c);
    endfunction

    function automatic int src_b(input int c);
        return int'(ins >> 5) & amask(c);
    endfunction

    function automatic logic [15:0] resolve(input int c, input int s);
        int m = amask(c);
        if (s == 0) return 16'h0;
        if (we_ex && (int'(rd_ex) & m) == s) return ans_ex & dmask(c);
        if (we_dm && (int'(rd_dm) & m) == s) return ans_dm & dmask(c);
        if (we_wb && (int'(rd_wb) & m) == s) return ans_wb & dmask(c);
        return m_rf[c][s];
    endfunction

    function automatic logic model_hazard(input int c);
        int r = int'(rd_ex) & amask(c);
        return ld_ex && we_ex && (r != 0) &&
               ((r == src_a(c)) || (!imm_sel && (r == src_b(c))));
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) m_rf[c][r] = 16'h0;
                m_a[c] = 16'h0;
                m_b[c] = 16'h0;
                m_v[c] = 1'b0;
            end else begin
                if (!stall) begin
                    if (flush || model_hazard(c)) begin
                        m_a[c] = 16'h0;
                        m_b[c] = 16'h0;
                        m_v[c] = 1'b0;
                    end else begin
                        m_a[c] = resolve(c, src_a(c));
                        m_b[c] = imm_sel ? (imm & dmask(c)) : resolve(c, src_b(c));
                        m_v[c] = 1'b1;
                    end
                end
                if (we_wb && (int'(rd_wb) & amask(c)) != 0)
                    m_rf[c][int'(rd_wb) & amask(c)] = ans_wb & dmask(c);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m8.A",     {8'h0, a8},   m_a[0]);
            check("m8.B",     {8'h0, b8},   m_b[0]);
            check("m8.valid", {15'h0, v8},  {15'h0, m_v[0]});
            check("m8.haz",   {15'h0, h8},  {15'h0, model_hazard(0)});
            check("m16.A",    a16,          m_a[1]);
            check("m16.B",    b16,          m_b[1]);
            check("m16.valid",{15'h0, v16}, {15'h0, m_v[1]});
            check("m16.haz",  {15'h0, h16}, {15'h0, model_hazard(1)});
        end
    end

    // ---------------- directed stimulus with literal expectations -----------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ins = '0; imm = '0; imm_sel = 0;
        rd_ex = '0; rd_dm = '0; rd_wb = '0;
        we_ex = 0; we_dm = 0; we_wb = 0; ld_ex = 0;
        ans_ex = '0; ans_dm = '0; ans_wb = '0;
        stall = 0; flush = 0;
    endtask

    function automatic logic [23:0] srcs(input int a, input int b);
        return 24'((a << 10) | (b << 5));
    endfunction

    initial begin
        rst = 1;
        idle();
        tick();
        rst = 0;
        chk_en = 1;

        // 1: post-reset read of empty registers
        check("t1.A0", {8'h0, a8}, 16'h0);
        check("t1.v0", {15'h0, v8}, 16'h0);
        ins = srcs(3, 4);
        tick();
        check("t1.A", {8'h0, a8}, 16'h00);
        check("t1.B", {8'h0, b8}, 16'h00);
        check("t1.v", {15'h0, v8}, 16'h1);

        // 2: write-through then file read
        we_wb = 1; rd_wb = 3; ans_wb = 16'h12E0; ins = srcs(3, 4);
        tick();
        check("t2.wt", {8'h0, a8}, 16'h00E0);
        we_wb = 0; ans_wb = 16'h0;
        tick();
        check("t2.rf8", {8'h0, a8}, 16'h00E0);
        check("t2.rf16", a16, 16'h12E0);

        // 3: forwarding priority EX > DM > WB
        ins = srcs(7, 4);
        we_ex = 1; we_dm = 1; we_wb = 1; rd_ex = 7; rd_dm = 7; rd_wb = 7;
        ans_ex = 16'hA1C0; ans_dm = 16'hA2D0; ans_wb = 16'hA3E0;
        tick();
        check("t3.ex", {8'h0, a8}, 16'h00C0);
        we_ex = 0;
        tick();
        check("t3.dm", {8'h0, a8}, 16'h00D0);
        we_dm = 0;
        tick();
        check("t3.wb", {8'h0, a8}, 16'h00E0);
        check("t3.wb16", a16, 16'hA3E0);

        // 4: immediate masks the load-use hazard on B
        idle();
        ins = srcs(1, 7); imm_sel = 1; imm = 16'h00FF;
        we_ex = 1; rd_ex = 7; ld_ex = 1;
        #1;
        check("t4.noh", {15'h0, h8}, 16'h0);
        tick();
        check("t4.B", {8'h0, b8}, 16'h00FF);
        imm_sel = 0;
        #1;
        check("t4.h", {15'h0, h8}, 16'h1);
        tick();
        check("t4.bv", {15'h0, v8}, 16'h0);
        check("t4.bA", {8'h0, a8}, 16'h0);
        check("t4.bB", {8'h0, b8}, 16'h0);

        // 5: stall holds, flush bubbles, reset beats stall
        idle();
        we_ex = 1; rd_ex = 5; ans_ex = 16'h0012;
        we_dm = 1; rd_dm = 6; ans_dm = 16'h0034;
        ins = srcs(5, 6);
        tick();
        check("t5.A", {8'h0, a8}, 16'h12);
        check("t5.B", {8'h0, b8}, 16'h34);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            ins = srcs(i + 8, i + 9); ans_ex = 16'(i * 16'h1111); ans_dm = 16'h7777;
            tick();
            check("t5.hA", {8'h0, a8}, 16'h12);
            check("t5.hB", {8'h0, b8}, 16'h34);
            check("t5.hv", {15'h0, v8}, 16'h1);
        end
        stall = 0; flush = 1;
        tick();
        check("t5.fA", {8'h0, a8}, 16'h0);
        check("t5.fv", {15'h0, v8}, 16'h0);
        flush = 0; ins = srcs(5, 6); ans_ex = 16'h0012;
        tick();
        check("t5.rv", {15'h0, v8}, 16'h1);
        stall = 1; rst = 1;
        tick();
        rst = 0;
        check("t5.rstA", {8'h0, a8}, 16'h0);
        check("t5.rstv", {15'h0, v8}, 16'h0);

        // 6: register 0 is never written or forwarded; wide forwarding
        idle();
        we_wb = 1; rd_wb = 0; ans_wb = 16'h00AA;
        we_ex = 1; rd_ex = 0; ans_ex = 16'h0055; ld_ex = 1;
        ins = srcs(0, 0);
        #1;
        check("t6.h8", {15'h0, h8}, 16'h0);
        check("t6.h16", {15'h0, h16}, 16'h0);
        tick();
        check("t6.A8", {8'h0, a8}, 16'h0);
        check("t6.A16", a16, 16'h0);
        check("t6.v", {15'h0, v8}, 16'h1);
        idle();
        we_dm = 1; rd_dm = 9; ans_dm = 16'hBEEF;
        ins = srcs(9, 9);
        tick();
        check("t6.wA16", a16, 16'hBEEF);
        check("t6.wB16", b16, 16'hBEEF);
        check("t6.wA8", {8'h0, a8}, 16'h00EF);

        idle();
        repeat (3) tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
